// File: rtl/adc_pkg.sv
// Shared constants and FSM state type for the AD0 ADC frame capture slice.
package adc_pkg;
  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 1024;
  localparam int ADDR_W    = 10;
  localparam int PHASE_W   = 32;
  localparam logic [PHASE_W-1:0] PHASE_INC = 32'd439804651;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    DONE
  } state_e;
endpackage

// File: rtl/adc_nco.sv
// Phase-accumulator NCO that produces AD0_CLK from the system clock, plus
// single-cycle rise/fall strobes of that clock in the system clock domain.
module adc_nco
  import adc_pkg::*;
#(
  parameter logic [PHASE_W-1:0] INC = PHASE_INC
) (
  input  logic clk,
  input  logic reset_n,
  output logic ad_clk,
  output logic rise,
  output logic fall
);

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic               ck_dly_q, ck_dly_d;

  always_comb begin
    acc_d    = acc_q + INC;
    ck_dly_d = acc_q[PHASE_W-1];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      ck_dly_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      ck_dly_q <= ck_dly_d;
    end
  end

  // The output comes straight from a flop, so AD0_CLK is glitch-free.
  assign ad_clk = acc_q[PHASE_W-1];
  assign rise   = ad_clk & ~ck_dly_q;
  assign fall   = ~ad_clk & ck_dly_q;

endmodule

// File: rtl/adc_frame_capture.sv
// Captures one FRAME_LEN-deep frame of AD0 samples into an inferred RAM.
// Build option: define ADC_OFFSET_BIN_EN to store samples as two's complement.
module adc_frame_capture
  import adc_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] AD0,
  output logic              AD0_CLK,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     wr_count_q, wr_count_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                sample_vld_q, sample_vld_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_en;
  logic                rise, fall;
  logic [DATA_W-1:0]   mem [FRAME_LEN];

  adc_nco u_nco (
    .clk     (clk),
    .reset_n (reset_n),
    .ad_clk  (AD0_CLK),
    .rise    (rise),
    .fall    (fall)
  );

`ifdef ADC_OFFSET_BIN_EN
  assign wr_data = {~sample_q[DATA_W-1], sample_q[DATA_W-2:0]};
`else
  assign wr_data = sample_q;
`endif

  // NOTE: every signal gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    wr_count_d   = wr_count_q;
    wr_en        = 1'b0;
    // Sample mid-period on the falling edge, well away from ADC transitions.
    sample_d     = fall ? AD0 : sample_q;
    sample_vld_d = fall;
    rd_data_d    = mem[rd_addr];
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ARM;
          wr_count_d = '0;
        end
      end
      ARM: begin
        if (rise) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (sample_vld_q) begin
          wr_en      = 1'b1;
          wr_count_d = wr_count_q + 1'b1;
          if (wr_count_q[ADDR_W-1:0] == ADDR_W'(FRAME_LEN - 1)) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_count_q   <= '0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_count_q   <= wr_count_d;
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // NOTE: the RAM has no reset so it maps onto block RAM; a partial frame
  // left behind by a reset is flagged only by wr_count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_count_q[ADDR_W-1:0]] <= wr_data;
  end

  assign busy     = (state_q == ARM) || (state_q == CAPTURE);
  assign done     = (state_q == DONE);
  assign wr_count = wr_count_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Scoreboard bench for adc_frame_capture: an ADC model drives AD0 from
// AD0_CLK, expected RAM contents are queued at start and checked on readback.
`timescale 1ns/1ps
module tb_adc_frame_capture;
  import adc_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [DATA_W-1:0] AD0 = '0;
  logic              AD0_CLK;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_count;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  adc_frame_capture dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .AD0      (AD0),
    .AD0_CLK  (AD0_CLK),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .wr_count (wr_count),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rd_item_t;

  rd_item_t    exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;

  // ADC model: k counts AD0_CLK rises; output settles a few ns after each rise.
  int unsigned       k = 0;
  bit                ramp_mode = 1'b1;
  logic [DATA_W-1:0] const_val = '0;

  always @(posedge AD0_CLK) begin
    k = k + 1;
    #3 AD0 = ramp_mode ? k[7:0] : const_val;
  end

  int   tb_cyc    = 0;
  int   rel_cyc   = 0;
  bit   rel_valid = 1'b0;
  int   rises     = 0;
  int   done_cnt  = 0;
  logic ck_prev   = 1'b0;

  always @(negedge clk) begin
    tb_cyc = tb_cyc + 1;
    if (rel_valid && (tb_cyc - rel_cyc) <= 10000 && AD0_CLK === 1'b1 && ck_prev === 1'b0)
      rises = rises + 1;
    ck_prev = AD0_CLK;
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns the ADC rise count just before the edge that accepts start.
  task automatic start_frame(output int unsigned kb);
    @(negedge clk);
    kb    = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_ramp(input int unsigned kb);
    rd_item_t it;
    for (int j = 0; j < FRAME_LEN; j++) begin
      it.addr = ADDR_W'(j);
      it.data = DATA_W'(kb + 1 + j);
      exp_q.push_back(it);
    end
  endtask

  task automatic wait_done(input string tag, input int dc0);
    int n = 0;
    while (done !== 1'b1 && n < 15000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(n < 15000), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_wr_count"}, 32'(wr_count), 32'(FRAME_LEN));
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt - dc0), 32'd1);
    check({tag, "_done_low"}, 32'(done), 32'd0);
  endtask

  task automatic read_check(input string tag);
    rd_item_t it;
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      @(negedge clk);
      rd_addr = it.addr;
      @(negedge clk);
      check($sformatf("%s_rd[%0d]", tag, it.addr), 32'(rd_data), 32'(it.data));
    end
  endtask

  initial begin
    int unsigned  kb;
    int           dc0;
    int           n;
    logic [ADDR_W:0] wc_before;
    logic [DATA_W-1:0] vals [3];
    rd_item_t     it;

    vals[0] = 8'h80;
    vals[1] = 8'hFF;
    vals[2] = 8'h00;
    reset_n = 1'b0;
    start   = 1'b0;
    rd_addr = '0;

    // Reset held for 100 ns with the clock running.
    #90;
    check("rst_ad0_clk", 32'(AD0_CLK), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    #10;
    @(negedge clk);
    reset_n   = 1'b1;
    rel_cyc   = tb_cyc;
    rel_valid = 1'b1;

    // Ramp frame.
    dc0 = done_cnt;
    start_frame(kb);
    push_ramp(kb);
    check("ramp_busy", 32'(busy), 32'd1);
    check("ramp_wr_count0", 32'(wr_count), 32'd0);
    wait_done("ramp", dc0);
    while ((tb_cyc - rel_cyc) <= 10005) @(negedge clk);
    check("rise_count_1024pm1", 32'(rises >= 1023 && rises <= 1025), 32'd1);
    read_check("ramp");

    // Extra start pulses one cycle after acceptance and mid-frame.
    dc0 = done_cnt;
    @(negedge clk);
    kb    = k;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    push_ramp(kb);
    repeat (5000) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    wc_before = wr_count;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_start_ignored", 32'(wr_count >= wc_before && wc_before > 0), 32'd1);
    wait_done("extra", dc0);
    repeat (20) @(negedge clk);
    check("extra_single_done", 32'(done_cnt - dc0), 32'd1);
    read_check("extra");

    // Reset after roughly 300 samples, then a clean frame.
    start_frame(kb);
    n = 0;
    while (wr_count < 300 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reach300", 32'(n < 5000), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_wr_count", 32'(wr_count), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_ad0_clk", 32'(AD0_CLK), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    dc0 = done_cnt;
    start_frame(kb);
    push_ramp(kb);
    check("restart_busy", 32'(busy), 32'd1);
    wait_done("restart", dc0);
    read_check("restart");

    // Constant mid-scale, full-scale and zero frames.
    ramp_mode = 1'b0;
    for (int f = 0; f < 3; f++) begin
      const_val = vals[f];
      dc0 = done_cnt;
      start_frame(kb);
      for (int a = 0; a < 4; a++) begin
        it.addr = (a == 0) ? 10'd0 : (a == 1) ? 10'd1 : (a == 2) ? 10'd512 : 10'd1023;
`ifdef ADC_OFFSET_BIN_EN
        it.data = vals[f] ^ 8'h80;
`else
        it.data = vals[f];
`endif
        exp_q.push_back(it);
      end
      wait_done($sformatf("const%0d", f), dc0);
      read_check($sformatf("const%0d", f));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
